// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, response tag,
// instruction/address widths.
package if_fetch_pkg;

    localparam int INST_BYTES = 4;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_DRAIN = 2'd1,
        IF_HOLD  = 2'd2
    } if_state_e;

    // Marks which assembly lane the byte on mem_din belongs to this cycle.
    typedef struct packed {
        logic       v;
        logic [1:0] lane;
    } resp_tag_t;

    function automatic inst_addr_t align_word(input inst_addr_t a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Memory-port, redirect and decode-handshake bundle of the fetch stage.
interface if_fetch_if;
    logic [31:0] mem_a_o;
    logic        mem_rd_o;
    logic [7:0]  mem_din_i;
    logic        mem_busy_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        id_ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    modport master (
        output mem_a_o, mem_rd_o, pc_o, inst_o, inst_valid_o,
        input  mem_din_i, mem_busy_i, branch_i, branch_target_i, id_ready_i
    );

    modport slave (
        input  mem_a_o, mem_rd_o, pc_o, inst_o, inst_valid_o,
        output mem_din_i, mem_busy_i, branch_i, branch_target_i, id_ready_i
    );
endinterface

// File: rtl/if_asm_buf.sv
// Byte-lane assembly buffer: tags each issued byte with its lane and captures
// the returning byte one cycle later; word exposes the lanes with the byte in flight bypassed.
module if_asm_buf
    import if_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    input  logic [1:0] issue_lane,
    input  logic       flush,
    input  logic [7:0] din,
    output inst_t      word
);

    resp_tag_t                    tag;
    logic [INST_BYTES-1:0][7:0]   lanes;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag <= '0;
        end else if (flush) begin
            tag <= '0;
        end else begin
            tag.v    <= issue;
            tag.lane <= issue_lane;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanes <= '0;
        end else if (flush) begin
            lanes <= '0;
        end else begin
            for (int k = 0; k < INST_BYTES; k++) begin
                if (tag.v && tag.lane == 2'(k)) lanes[k] <= din;
            end
        end
    end

    // Bypass lets the DRAIN cycle load the output with byte 3 straight off the bus.
    always_comb begin
        word = ZERO_WORD;
        for (int k = 0; k < INST_BYTES; k++) begin
            word[8*k +: 8] = (tag.v && tag.lane == 2'(k)) ? din : lanes[k];
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: issues four byte reads per instruction over the shared port,
// assembles them little-endian and presents pc/inst to decode with a valid/ready handshake.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst,
    if_fetch_if.master bus
);

    if_state_e  state, state_nxt;
    inst_addr_t fetch_pc, fetch_pc_nxt;
    logic [2:0] idx, idx_nxt;
    logic       slot_free;
    logic       rd;
    logic       load;
    inst_t      word;

    assign slot_free = !bus.inst_valid_o || bus.id_ready_i;

    // idx reaches 4 after byte 3, so fetch_pc+idx already points at the next word in DRAIN.
    assign rd = rst && !bus.mem_busy_i && !bus.branch_i &&
                (state == IF_FETCH || (state == IF_DRAIN && slot_free));
    assign bus.mem_rd_o = rd;
    assign bus.mem_a_o  = fetch_pc + {29'd0, idx};

    if_asm_buf u_asm (
        .clk        (clk),
        .rst        (rst),
        .issue      (rd),
        .issue_lane (idx[1:0]),
        .flush      (bus.branch_i),
        .din        (bus.mem_din_i),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IF_FETCH;
            fetch_pc <= RESET_PC;
            idx      <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            idx      <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        idx_nxt      = idx;
        load         = 1'b0;
        if (bus.branch_i) begin
            state_nxt    = IF_FETCH;
            fetch_pc_nxt = align_word(bus.branch_target_i);
            idx_nxt      = '0;
        end else begin
            case (state)
                IF_FETCH: begin
                    if (rd) begin
                        idx_nxt = idx + 3'd1;
                        if (idx == 3'd3) state_nxt = IF_DRAIN;
                    end
                end
                IF_DRAIN: begin
                    if (slot_free) begin
                        load         = 1'b1;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        idx_nxt      = rd ? 3'd1 : 3'd0;
                        state_nxt    = IF_FETCH;
                    end else begin
                        state_nxt = IF_HOLD;
                    end
                end
                IF_HOLD: begin
                    if (slot_free) begin
                        load         = 1'b1;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        idx_nxt      = '0;
                        state_nxt    = IF_FETCH;
                    end
                end
                default: begin
                    state_nxt = IF_FETCH;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.inst_valid_o <= 1'b0;
            bus.pc_o         <= ZERO_WORD;
            bus.inst_o       <= ZERO_WORD;
        end else if (bus.branch_i) begin
            bus.inst_valid_o <= 1'b0;
        end else if (load) begin
            bus.inst_valid_o <= 1'b1;
            bus.pc_o         <= fetch_pc;
            bus.inst_o       <= word;
        end else if (bus.id_ready_i) begin
            bus.inst_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle-exact vector table, hand sequences, and a random run
// checked against a stream-level model of the fetch rules.
module tb_if_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_if bus();
    if_fetch #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    int vec_cnt = 0;
    int err_cnt = 0;
    bit mon_on  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] lo, hi;
        lo = a[7:0];
        hi = a[15:8];
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return (lo * 8'd29) ^ hi ^ 8'h6B;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Memory: byte read in cycle n appears in cycle n+1; junk otherwise.
    logic        pend_rd;
    logic [31:0] pend_a;
    always @(negedge clk) begin
        pend_rd = bus.mem_rd_o;
        pend_a  = bus.mem_a_o;
    end
    always @(posedge clk) bus.mem_din_i <= pend_rd ? mem_byte(pend_a) : 8'($urandom);

    // Stream model: issues are consecutive bytes from the current fetch origin,
    // presented pcs advance by 4 per accept, a redirect restarts both at the target.
    logic [31:0] exp_issue, exp_pc, prev_pc, prev_inst;
    bit          prev_hold, prev_br;
    int          since = 0;
    int          acc_cnt = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (!rst) begin
                chk("rst_rd", {31'd0, bus.mem_rd_o}, 32'd0);
                chk("rst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
                chk("rst_pc", bus.pc_o, 32'd0);
                chk("rst_inst", bus.inst_o, 32'd0);
                exp_issue = 32'd0;
                exp_pc    = 32'd0;
                prev_hold = 1'b0;
                prev_br   = 1'b0;
                since     = 0;
            end else begin
                if (bus.mem_rd_o) begin
                    chk("rd_gate", {30'd0, bus.mem_busy_i, bus.branch_i}, 32'd0);
                    chk("issue_addr", bus.mem_a_o, exp_issue);
                    exp_issue = exp_issue + 32'd1;
                end
                if (prev_br) chk("valid_after_branch", {31'd0, bus.inst_valid_o}, 32'd0);
                if (prev_hold) begin
                    chk("hold_valid", {31'd0, bus.inst_valid_o}, 32'd1);
                    chk("hold_pc", bus.pc_o, prev_pc);
                    chk("hold_inst", bus.inst_o, prev_inst);
                end
                if (bus.inst_valid_o) begin
                    chk("out_pc", bus.pc_o, exp_pc);
                    chk("out_inst", bus.inst_o, mem_word(bus.pc_o));
                    since = 0;
                end else begin
                    since++;
                    if (since == 200) chk("liveness_stall", since, 32'd0);
                end
                if (bus.branch_i) begin
                    exp_issue = bus.branch_target_i & ~32'd3;
                    exp_pc    = bus.branch_target_i & ~32'd3;
                end else if (bus.inst_valid_o && bus.id_ready_i) begin
                    exp_pc = exp_pc + 32'd4;
                    acc_cnt++;
                end
                prev_hold = bus.inst_valid_o && !bus.id_ready_i && !bus.branch_i;
                prev_br   = bus.branch_i;
                prev_pc   = bus.pc_o;
                prev_inst = bus.inst_o;
            end
        end
    end

    typedef struct {
        bit          rst, busy, br;
        logic [31:0] tgt;
        bit          rdy, erd;
        logic [31:0] ea;
        bit          ev;
        logic [31:0] epc, einst;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit r, input bit b, input bit br, input logic [31:0] tgt, input bit rdy,
                       input bit erd, input logic [31:0] ea, input bit ev, input logic [31:0] epc);
        vec_t v;
        v = '{r, b, br, tgt, rdy, erd, ea, ev, epc, ev ? mem_word(epc) : 32'd0};
        tbl.push_back(v);
    endtask
    task automatic rv();                                          add(0, 0, 0, 0, 1, 0, 0, 0, 0);  endtask
    task automatic f(input bit rdy, input logic [31:0] a);        add(1, 0, 0, 0, rdy, 1, a, 0, 0); endtask
    task automatic fv(input bit rdy, input logic [31:0] a, input logic [31:0] pc); add(1, 0, 0, 0, rdy, 1, a, 1, pc); endtask
    task automatic hv(input bit rdy, input logic [31:0] pc);      add(1, 0, 0, 0, rdy, 0, 0, 1, pc); endtask

    task automatic drive(input bit r, input bit b, input bit br, input logic [31:0] tgt, input bit rdy);
        rst = r;
        bus.mem_busy_i = b;
        bus.branch_i = br;
        bus.branch_target_i = tgt;
        bus.id_ready_i = rdy;
    endtask

    initial begin
        int k;
        drive(1, 0, 0, 0, 1);
        #3 rst = 1'b0;
        mon_on = 1'b1;

        // First instruction, then back-to-back at pc 0,4,8.
        rv();
        for (int a = 0; a < 5; a++) f(1, a);
        fv(1, 5, 0); f(1, 6); f(1, 7); f(1, 8); fv(1, 9, 4);
        f(1, 10); f(1, 11); f(1, 12); fv(1, 13, 8);
        // Decode stalls after the first instruction: DRAIN -> HOLD, no issue.
        rv();
        for (int a = 0; a < 5; a++) f(1, a);
        fv(0, 5, 0); fv(0, 6, 0); fv(0, 7, 0);
        hv(0, 0); hv(0, 0); hv(0, 0); hv(1, 0);
        fv(1, 8, 4); f(1, 9);
        // Busy for three cycles after byte 1.
        rv();
        f(1, 0); f(1, 1);
        for (int n = 0; n < 3; n++) add(1, 1, 0, 0, 1, 0, 0, 0, 0);
        f(1, 2); f(1, 3); f(1, 4); fv(1, 5, 0); f(1, 6);
        // Redirect to 0x106 where byte 2 would issue.
        rv();
        f(1, 0); f(1, 1);
        add(1, 0, 1, 32'h106, 1, 0, 0, 0, 0);
        for (int a = 'h104; a <= 'h108; a++) f(1, a);
        fv(1, 32'h109, 32'h104);
        // Redirect while an instruction is held: it must vanish.
        rv();
        for (int a = 0; a < 5; a++) f(1, a);
        fv(0, 5, 0);
        add(1, 0, 1, 32'h40, 0, 0, 0, 1, 0);
        for (int a = 'h40; a <= 'h44; a++) f(0, a);
        fv(0, 32'h45, 32'h40);
        // Address wrap through 2^32.
        rv();
        add(1, 0, 1, 32'hFFFF_FFFE, 1, 0, 0, 0, 0);
        f(1, 32'hFFFF_FFFC); f(1, 32'hFFFF_FFFD); f(1, 32'hFFFF_FFFE); f(1, 32'hFFFF_FFFF);
        f(1, 32'h0); fv(1, 32'h1, 32'hFFFF_FFFC);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i].rst, tbl[i].busy, tbl[i].br, tbl[i].tgt, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("v%0d_rd", i), {31'd0, bus.mem_rd_o}, {31'd0, tbl[i].erd});
            if (tbl[i].erd) chk($sformatf("v%0d_addr", i), bus.mem_a_o, tbl[i].ea);
            chk($sformatf("v%0d_valid", i), {31'd0, bus.inst_valid_o}, {31'd0, tbl[i].ev});
            if (tbl[i].ev || !tbl[i].rst) begin
                chk($sformatf("v%0d_pc", i), bus.pc_o, tbl[i].epc);
                chk($sformatf("v%0d_inst", i), bus.inst_o, tbl[i].einst);
            end
        end

        // Reset in the middle of a fetch discards partial bytes and refetches from 0.
        @(posedge clk); #1; drive(0, 0, 0, 0, 1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.inst_valid_o) break;
            @(posedge clk); #1;
        end
        chk("reset_refetch_latency", k, 32'd5);
        chk("reset_refetch_pc", bus.pc_o, 32'd0);
        chk("reset_refetch_inst", bus.inst_o, 32'h0010_0513);

        // Random traffic against the stream model.
        acc_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            @(posedge clk); #1;
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            drive(1, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, tgt, $urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        chk("random_accepts_ge100", {31'd0, acc_cnt >= 100}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
